mc_cpu: RTL and testbench



---
 rtl/mc_cpu_if.sv | 24 ++
 rtl/mc_cpu.sv | 237 +++++++++++++++++++++++
 tb/tb_mc_cpu.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_cpu_if.sv
// Shared instruction/data memory port between the core and the memory model.
// Zero latency; it carries wires only.
// Backpressure: the slave holds off completion by keeping mem_ack low while mem_req is high.
interface mc_cpu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mc_cpu.sv
// Multi-cycle 16-bit MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Latency with zero-wait memory: R-type/addi 4, lw 5, sw 4, beq/nop 2 cycles; each wait state adds 1 per access.
// Backpressure: every access holds its request registers stable until mem_ack; mem_ack with mem_req low is ignored.
module mc_cpu #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  mc_cpu_if.master          mem,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic              wb_valid,
  output logic [1:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [15:0]       ir_q, ir_n;
  logic [DATA_W-1:0] a_q, a_n, b_q, b_n, res_q, res_n;
  logic              req_q, req_n, we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              wbv_q, wbv_n;
  logic [1:0]        wbr_q, wbr_n;
  logic [DATA_W-1:0] wbd_q, wbd_n;
  logic              halt_q, halt_n;
  logic              rf_we;
  logic [1:0]        rf_wa;
  logic [DATA_W-1:0] rf [4];

  logic [3:0]        op;
  logic [1:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] rs_val, rt_val, alu;
  logic              is_alu, is_mem;

  assign op     = ir_q[15:12];
  assign rs     = ir_q[11:10];
  assign rt     = ir_q[9:8];
  assign rd     = ir_q[7:6];
  assign imm_d  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  // pc already points past the branch, so the offset is relative to the next instruction
  assign target = pc_q + {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};
  // r0 is never written, so it always reads back as zero
  assign rs_val = rf[rs];
  assign rt_val = rf[rt];
  assign is_alu = (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI});
  assign is_mem = (op == OP_LW) || (op == OP_SW);

  // ALU on the operands latched in DECODE; lw/sw reuse the addi path for rs+imm
  always_comb begin
    alu = a_q + imm_d;
    case (op)
      OP_ADD:  alu = a_q + b_q;
      OP_SUB:  alu = a_q - b_q;
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_SLT:  alu = ($signed(a_q) < $signed(b_q)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      default: alu = a_q + imm_d;
    endcase
  end

  // Controller: next-state and next-value of every architectural and port register
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    ir_n    = ir_q;
    a_n     = a_q;
    b_n     = b_q;
    res_n   = res_q;
    req_n   = req_q;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    wbv_n   = 1'b0;
    wbr_n   = wbr_q;
    wbd_n   = wbd_q;
    halt_n  = halt_q;
    rf_we   = 1'b0;
    rf_wa   = 2'd0;
    case (state)
      S_FETCH: begin
        // Entered with req low after reset or a store: raise the fetch request here
        if (!req_q) begin
          req_n  = 1'b1;
          we_n   = 1'b0;
          addr_n = pc_q;
        end else if (mem.mem_ack) begin
          ir_n    = mem.mem_rdata[15:0];
          pc_n    = pc_q + 1'b1;
          req_n   = 1'b0;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        a_n = rs_val;
        b_n = rt_val;
        if (op == OP_HALT) begin
          halt_n  = 1'b1;
          state_n = S_HALT;
        end else if (is_alu || is_mem) begin
          state_n = S_EXEC;
        end else begin
          // beq and NOPs go straight back to fetch, issuing the request in the same edge
          if ((op == OP_BEQ) && (rs_val == rt_val)) begin
            pc_n   = target;
            addr_n = target;
          end else begin
            addr_n = pc_q;
          end
          req_n   = 1'b1;
          we_n    = 1'b0;
          state_n = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_mem) begin
          req_n   = 1'b1;
          we_n    = (op == OP_SW);
          addr_n  = alu[ADDR_W-1:0];
          wdata_n = b_q;
          state_n = S_MEM;
        end else begin
          res_n   = alu;
          state_n = S_WB;
        end
      end
      S_MEM: begin
        if (mem.mem_ack) begin
          req_n = 1'b0;
          we_n  = 1'b0;
          if (op == OP_LW) begin
            res_n   = mem.mem_rdata;
            state_n = S_WB;
          end else begin
            // req must drop for a cycle after the store ack; FETCH re-raises it
            state_n = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_wa   = ((op == OP_ADDI) || (op == OP_LW)) ? rt : rd;
        rf_we   = (rf_wa != 2'd0);
        wbv_n   = 1'b1;
        wbr_n   = rf_wa;
        wbd_n   = res_q;
        req_n   = 1'b1;
        we_n    = 1'b0;
        addr_n  = pc_q;
        state_n = S_FETCH;
      end
      S_HALT: begin
        req_n = 1'b0;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // State registers; reset also kills any in-flight access asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbv_q   <= 1'b0;
      wbr_q   <= '0;
      wbd_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      ir_q    <= ir_n;
      a_q     <= a_n;
      b_q     <= b_n;
      res_q   <= res_n;
      req_q   <= req_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      wbv_q   <= wbv_n;
      wbr_q   <= wbr_n;
      wbd_q   <= wbd_n;
      halt_q  <= halt_n;
    end
  end

  // Register file write; r0 writes are dropped though wb_valid still reports them
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rf_wa] <= res_q;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign pc            = pc_q;
  assign ir            = ir_q;
  assign wb_valid      = wbv_q;
  assign wb_reg        = wbr_q;
  assign wb_data       = wbd_q;
  assign halted        = halt_q;

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: program tables with hand-computed writebacks plus multi-cycle corner sequences.
// Memory model answers on the negedge with a programmable wait count and optional stray acks.
// All waits on the DUT are bounded by cycle budgets.
module tb_mc_cpu;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  mc_cpu_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic          wb_valid;
  logic [1:0]    wb_reg;
  logic [DW-1:0] wb_data;
  logic          halted;

  mc_cpu #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0)) dut (
    .clock(clock), .reset_n(reset_n), .mem(bus), .pc(pc), .ir(ir),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .halted(halted)
  );

  typedef struct { int start; int ackc; int addr; logic we; int wdata; } acc_t;
  typedef struct { int rg; int data; int cyc; } wb_t;
  typedef struct { logic [15:0] instr; int wreg; int wdata; int cycles; } vec_t;

  logic [15:0] mem_arr [256];
  acc_t acc_q[$];
  wb_t  wb_q[$];
  int   cyc = 0, ws = 0, cnt = 0, st = 0, cur_addr = -1;
  bit   stray = 0, in_acc = 0, prev_req = 0, prev_ack = 0, p_we = 0;
  int   p_addr = 0, p_wdata = 0;
  int   hold_viol = 0, gap_viol = 0, req_cycles = 0;
  int   checks = 0, errors = 0;

  // Memory responder and bus monitor, all on the negedge so the DUT sees stable ack at the posedge
  always @(negedge clock) begin
    if (!reset_n) begin
      bus.mem_ack = 1'b0; bus.mem_rdata = '0; cnt = 0; in_acc = 0; prev_req = 0; prev_ack = 0;
    end else begin
      if (wb_valid) begin
        wb_t w; w.rg = int'(wb_reg); w.data = int'(wb_data); w.cyc = cyc; wb_q.push_back(w);
      end
      if (bus.mem_req) begin
        req_cycles++;
        if (prev_req && !prev_ack && (int'(bus.mem_addr) != p_addr || bus.mem_we != p_we ||
            int'(bus.mem_wdata) != p_wdata)) hold_viol++;
        if (prev_req && prev_ack) gap_viol++;
        if (!in_acc) begin in_acc = 1; st = cyc; cur_addr = int'(bus.mem_addr); end
        if (cnt >= ws) begin
          acc_t a;
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mem_arr[bus.mem_addr[7:0]];
          if (bus.mem_we) mem_arr[bus.mem_addr[7:0]] = bus.mem_wdata;
          a.start = st; a.ackc = cyc; a.addr = int'(bus.mem_addr); a.we = bus.mem_we;
          a.wdata = int'(bus.mem_wdata);
          acc_q.push_back(a);
          in_acc = 0; cnt = 0;
        end else begin
          bus.mem_ack = 1'b0; bus.mem_rdata = 16'hDEAD; cnt++;
        end
      end else begin
        bus.mem_ack = stray; bus.mem_rdata = 16'hFFFF; cnt = 0;
      end
      prev_req = bus.mem_req; prev_ack = bus.mem_ack;
      p_addr = int'(bus.mem_addr); p_we = bus.mem_we; p_wdata = int'(bus.mem_wdata);
    end
    cyc++;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    acc_q.delete(); wb_q.delete();
    hold_viol = 0; gap_viol = 0; cur_addr = -1;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h9000;
  endtask

  task automatic wait_halt(input int lim);
    int n = 0;
    while (!halted && n < lim) begin @(negedge clock); #1; n++; end
    check("halt_reached", halted, 1);
  endtask

  function automatic int find_acc(input int a, input logic w);
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i].addr == a && acc_q[i].we == w) return i;
    return -1;
  endfunction

  function automatic int find_wb(input int r);
    for (int i = 0; i < wb_q.size(); i++) if (wb_q[i].rg == r) return i;
    return -1;
  endfunction

  vec_t tbl[8];

  task automatic run_table(input string tag);
    load_nops();
    for (int i = 0; i < 8; i++) mem_arr[i] = tbl[i].instr;
    mem_arr[8] = 16'hF000;
    do_reset();
    wait_halt(400);
    check({tag, "_wb_count"}, wb_q.size(), 8);
    if (wb_q.size() == 8 && acc_q.size() >= 9) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("%s_wb_reg[%0d]", tag, i), wb_q[i].rg, tbl[i].wreg);
        check($sformatf("%s_wb_data[%0d]", tag, i), wb_q[i].data, tbl[i].wdata);
        check($sformatf("%s_latency[%0d]", tag, i), acc_q[i+1].start - acc_q[i].start, tbl[i].cycles + ws);
      end
    end else begin
      check({tag, "_trace_complete"}, 0, 1);
    end
  endtask

  initial begin
    int i10, ilw, isw, iw, n, snap;
    tbl[0] = '{16'h410F, 1, 15, 4};
    tbl[1] = '{16'h4207, 2, 7, 4};
    tbl[2] = '{16'h26C0, 3, 7, 4};
    tbl[3] = '{16'h1780, 2, 8, 4};
    tbl[4] = '{16'h3B80, 2, 15, 4};
    tbl[5] = '{16'h0BC0, 3, 22, 4};
    tbl[6] = '{16'h7E40, 1, 0, 4};
    tbl[7] = '{16'h7B40, 1, 1, 4};
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    load_nops();

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_halted", halted, 0);

    // Zero-wait program, then wait states with stray acks on idle cycles
    ws = 0; stray = 0;
    run_table("zw");
    ws = 3; stray = 1;
    run_table("ws");
    check("ws_hold_stable", hold_viol, 0);
    check("ws_req_drop_after_ack", gap_viol, 0);

    // Store then load through address 4
    ws = 0; stray = 0; load_nops();
    mem_arr[0] = 16'h4316; mem_arr[1] = 16'h6304; mem_arr[2] = 16'h5104; mem_arr[3] = 16'hF000;
    do_reset();
    wait_halt(200);
    iw = find_acc(4, 1'b1); isw = find_acc(1, 1'b0); ilw = find_acc(2, 1'b0); n = find_wb(1);
    if (iw >= 0 && isw >= 0 && ilw >= 0 && n >= 0) begin
      check("sw_wdata", acc_q[iw].wdata, 22);
      check("sw_cycles", acc_q[iw].ackc - acc_q[isw].start + 1, 4);
      check("lw_wb_data", wb_q[n].data, 22);
      check("lw_wb_delay", wb_q[n].cyc - acc_q[ilw].start, 5);
    end else check("ls_trace", 0, 1);
    check("mem4_after_sw", mem_arr[4], 22);
    check("ls_hold_stable", hold_viol, 0);

    // Taken branch at 10, untaken at 13, self-loop at 14
    load_nops();
    mem_arr[0] = 16'h4105; mem_arr[1] = 16'h4203;
    mem_arr[10] = 16'h8502; mem_arr[11] = 16'hF000; mem_arr[12] = 16'hF000;
    mem_arr[13] = 16'h8602; mem_arr[14] = 16'h80FF;
    do_reset();
    repeat (80) @(negedge clock);
    #1;
    i10 = find_acc(10, 1'b0);
    if (i10 >= 0 && acc_q.size() > i10 + 4 && find_acc(3, 1'b0) >= 0) begin
      check("beq_taken_addr", acc_q[i10+1].addr, 13);
      check("beq_taken_cycles", acc_q[i10+1].start - acc_q[i10].start, 2);
      check("beq_untaken_addr", acc_q[i10+2].addr, 14);
      check("beq_untaken_cycles", acc_q[i10+2].start - acc_q[i10+1].start, 2);
      check("self_loop_addr", acc_q[i10+4].addr, 14);
      check("self_loop_cycles", acc_q[i10+4].start - acc_q[i10+3].start, 2);
      check("nop_cycles", acc_q[find_acc(3, 1'b0)].start - acc_q[find_acc(2, 1'b0)].start, 2);
    end else check("branch_trace", 0, 1);
    check("branch_not_halted", halted, 0);

    // Writes to r0 and HALT
    load_nops();
    mem_arr[0] = 16'h4005; mem_arr[1] = 16'h0040; mem_arr[2] = 16'hF000;
    do_reset();
    wait_halt(100);
    if (wb_q.size() == 2) begin
      check("r0_wb_reg", wb_q[0].rg, 0);
      check("r0_wb_data", wb_q[0].data, 5);
      check("r0_reads_zero_reg", wb_q[1].rg, 1);
      check("r0_reads_zero_data", wb_q[1].data, 0);
    end else check("r0_wb_count", wb_q.size(), 2);
    snap = req_cycles;
    repeat (20) @(negedge clock);
    #1;
    check("halt_no_req", req_cycles - snap, 0);
    check("halt_stays", halted, 1);
    check("halt_pc", pc, 3);

    // Reset two cycles into a waited fetch at pc=6
    ws = 3; stray = 1; load_nops();
    mem_arr[0] = 16'h4109;
    do_reset();
    n = 0;
    while (!(in_acc && cur_addr == 6) && n < 200) begin @(negedge clock); #2; n++; end
    check("mid_fetch_reached", (in_acc && cur_addr == 6), 1);
    check("pre_reset_r1", dut.rf[1], 9);
    @(posedge clock); @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", bus.mem_req, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_r1", dut.rf[1], 0);
    check("mid_rst_ir", ir, 0);
    @(negedge clock);
    acc_q.delete(); wb_q.delete();
    #2 reset_n = 1'b1;
    n = 0;
    while (wb_q.size() < 1 && n < 200) begin @(negedge clock); #1; n++; end
    if (wb_q.size() >= 1 && acc_q.size() >= 1) begin
      check("post_rst_first_addr", acc_q[0].addr, 0);
      check("post_rst_wb_reg", wb_q[0].rg, 1);
      check("post_rst_wb_data", wb_q[0].data, 9);
    end else check("post_rst_trace", 0, 1);
    check("post_rst_not_halted", halted, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
